// File: rtl/mem_view_ctrl.sv
// -----------------------------------------------------------------------------
// mem_view_ctrl
//
// Front-panel memory inspector. A single bouncing pushbutton steps an 8-bit
// inspection address up or down. Each accepted step issues one read of the
// new address and latches the returned 16-bit word. The address and the
// selected byte of the latched word are presented as nibbles for a 4-digit
// display controller. After every reset one read of address 0x00 is issued
// automatically, so the display never shows stale data after power-up.
//
// Ports
//   clk_in     in   1   system clock, rising-edge active
//   reset      in   1   asynchronous, active-high reset
//   step_btn   in   1   raw pushbutton (unsynchronized, bouncing)
//   dir        in   1   step direction: 0 = increment, 1 = decrement
//   byte_sel   in   1   displayed byte: 0 = low byte, 1 = high byte
//   mem_rdata  in  16   memory read data
//   mem_addr   out  8   current inspection address
//   mem_rd     out  1   one-cycle read strobe
//   busy       out  1   high while a read is in progress
//   S_hi/S_lo  out 4/4  mem_addr[7:4] / mem_addr[3:0]
//   R_hi/R_lo  out 4/4  high / low nibble of the selected latched byte
//   fsm_state  out  2   controller state (IDLE=0, READ=1, WAIT=2, LATCH=3)
//
// Memory handshake: mem_rd is a one-cycle request with mem_addr held stable
// for that cycle; the memory has no ready/stall. mem_rdata must be valid
// exactly RD_LATENCY cycles after the cycle mem_rd is high, which is the
// LATCH cycle, and is captured on the rising edge that ends LATCH.
// No new request is issued until the current one has been latched.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive disagreeing synchronized samples needed
//                    before the debounced level follows the button (>= 1)
//   RD_LATENCY       memory read latency in cycles, 1..7
// -----------------------------------------------------------------------------
module mem_view_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RD_LATENCY      = 1
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        step_btn,
  input  logic        dir,
  input  logic        byte_sel,
  input  logic [15:0] mem_rdata,
  output logic [7:0]  mem_addr,
  output logic        mem_rd,
  output logic        busy,
  output logic [3:0]  S_hi,
  output logic [3:0]  S_lo,
  output logic [3:0]  R_hi,
  output logic [3:0]  R_lo,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WAIT  = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  // Counter wide enough to hold DEBOUNCE_CYCLES-1 even when it is 0.
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // WAIT lasts RD_LATENCY-1 cycles; the counter is loaded with the number
  // of extra WAIT cycles still to spend after the first one.
  localparam logic [2:0]      WAIT_INIT = 3'(RD_LATENCY - 2);

  // ---------------------------------------------------------------------------
  // Button conditioning: 2-flop synchronizer, then a debounce counter that
  // counts consecutive cycles the synchronized level disagrees with the
  // debounced level. Any agreeing cycle clears the count.
  // ---------------------------------------------------------------------------
  logic             sync1;
  logic             sync2;
  logic             deb;
  logic             deb_d1;
  logic [CNT_W-1:0] deb_cnt;
  logic             step_pulse;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb     <= 1'b0;
      deb_d1  <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1  <= step_btn;
      sync2  <= sync1;
      deb_d1 <= deb;
      if (sync2 != deb) begin
        if (deb_cnt == CNT_LAST) begin
          deb     <= sync2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // One-cycle pulse on the rising edge of the debounced level only.
  assign step_pulse = deb & ~deb_d1;

  // ---------------------------------------------------------------------------
  // Read controller. Reset parks the FSM in READ so that the first cycle
  // after deassertion issues the automatic read of address 0x00.
  // Step pulses outside IDLE are simply not looked at, so they are dropped.
  // ---------------------------------------------------------------------------
  state_t      state;
  logic [2:0]  wait_cnt;
  logic [15:0] data_q;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state    <= S_READ;
      mem_addr <= 8'h00;
      data_q   <= 16'h0000;
      wait_cnt <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (step_pulse) begin
            // dir is only looked at on the accepting cycle; 8-bit wrap.
            mem_addr <= dir ? (mem_addr - 8'd1) : (mem_addr + 8'd1);
            state    <= S_READ;
          end
        end
        S_READ: begin
          if (RD_LATENCY == 1) begin
            state <= S_LATCH;
          end else begin
            state    <= S_WAIT;
            wait_cnt <= WAIT_INIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 3'd0) begin
            state <= S_LATCH;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        S_LATCH: begin
          data_q <= mem_rdata;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The request strobe is a decode of the state register. It is gated by
  // reset because reset parks the FSM in READ, yet no request may be made
  // while reset is held.
  assign mem_rd    = (state == S_READ) && !reset;
  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

  // ---------------------------------------------------------------------------
  // Display nibbles. The data digits come straight from the latched word so
  // a byte_sel change is visible at once, without a new memory read.
  // ---------------------------------------------------------------------------
  logic [7:0] sel_byte;

  assign sel_byte = byte_sel ? data_q[15:8] : data_q[7:0];
  assign S_hi     = mem_addr[7:4];
  assign S_lo     = mem_addr[3:0];
  assign R_hi     = sel_byte[7:4];
  assign R_lo     = sel_byte[3:0];

endmodule

// File: tb/tb_mem_view_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_view_ctrl
//
// Two instances share the button/direction/byte-select/reset stimulus:
//   a: DEBOUNCE_CYCLES=4, RD_LATENCY=1
//   b: DEBOUNCE_CYCLES=1, RD_LATENCY=3 (short debounce lets two step pulses
//      land inside one read)
// Each instance has its own memory model that returns the stored word only
// in the cycle the data is due and random garbage otherwise, so a capture
// on the wrong cycle shows up as wrong display data.
// -----------------------------------------------------------------------------
module tb_mem_view_ctrl;

  localparam int DB_A  = 4;
  localparam int LAT_A = 1;
  localparam int DB_B  = 1;
  localparam int LAT_B = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset    = 1'b0;
  logic        step_btn = 1'b0;
  logic        dir      = 1'b0;
  logic        byte_sel = 1'b0;
  logic [15:0] rdata_a  = 16'h0;
  logic [15:0] rdata_b  = 16'h0;

  logic [7:0] addr_a, addr_b;
  logic       rd_a, rd_b, busy_a, busy_b;
  logic [3:0] s_hi_a, s_lo_a, r_hi_a, r_lo_a;
  logic [3:0] s_hi_b, s_lo_b, r_hi_b, r_lo_b;
  logic [1:0] st_a, st_b;

  mem_view_ctrl #(.DEBOUNCE_CYCLES(DB_A), .RD_LATENCY(LAT_A)) dut_a (
    .clk_in(clk), .reset(reset), .step_btn(step_btn), .dir(dir),
    .byte_sel(byte_sel), .mem_rdata(rdata_a), .mem_addr(addr_a),
    .mem_rd(rd_a), .busy(busy_a), .S_hi(s_hi_a), .S_lo(s_lo_a),
    .R_hi(r_hi_a), .R_lo(r_lo_a), .fsm_state(st_a)
  );

  mem_view_ctrl #(.DEBOUNCE_CYCLES(DB_B), .RD_LATENCY(LAT_B)) dut_b (
    .clk_in(clk), .reset(reset), .step_btn(step_btn), .dir(dir),
    .byte_sel(byte_sel), .mem_rdata(rdata_b), .mem_addr(addr_b),
    .mem_rd(rd_b), .busy(busy_b), .S_hi(s_hi_b), .S_lo(s_lo_b),
    .R_hi(r_hi_b), .R_lo(r_lo_b), .fsm_state(st_b)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int rd_cnt_a = 0;
  int rd_cnt_b = 0;
  int cyc = 0;

  int db_p  [2] = '{DB_A, DB_B};
  int lat_p [2] = '{LAT_A, LAT_B};

  logic [15:0] mem [256];

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural reference model.
  //   synchronized level = raw button two edges ago
  //   debounced level follows it after db_p consecutive disagreeing cycles
  //   step = debounced level is 1 now and was 0 last cycle
  //   m_t = cycles since the current read began (-1 when no read); a read
  //   spans cycles 0..latency, request in cycle 0, capture at end of the last
  // ---------------------------------------------------------------------------
  bit          m_s1       [2];
  bit          m_s2       [2];
  bit          m_deb      [2];
  bit          m_deb_prev [2];
  int          m_run      [2];
  int          m_t        [2] = '{0, 0};
  logic [7:0]  m_addr     [2] = '{8'h00, 8'h00};
  logic [15:0] m_data     [2] = '{16'h0000, 16'h0000};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_deb_prev[i] = 0;
        m_run[i] = 0; m_t[i] = 0; m_addr[i] = 8'h00; m_data[i] = 16'h0000;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit pulse;
        pulse = m_deb[i] && !m_deb_prev[i];
        if (m_t[i] < 0) begin
          if (pulse) begin
            m_addr[i] = dir ? m_addr[i] - 8'd1 : m_addr[i] + 8'd1;
            m_t[i] = 0;
          end
        end else if (m_t[i] == lat_p[i]) begin
          m_data[i] = mem[m_addr[i]];
          m_t[i] = -1;
        end else begin
          m_t[i]++;
        end
        m_deb_prev[i] = m_deb[i];
        if (m_s2[i] != m_deb[i]) begin
          m_run[i]++;
          if (m_run[i] == db_p[i]) begin
            m_deb[i] = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = step_btn;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Memory models: a request seen in cycle c is answered in cycle c+latency.
  // ---------------------------------------------------------------------------
  bit         req_v [2][16];
  logic [7:0] req_a [2][16];

  task automatic mem_cycle(input int i, input logic rd, input logic [7:0] addr,
                           output logic [15:0] rdata);
    int slot;
    int due;
    slot = cyc % 16;
    if (req_v[i][slot]) begin
      rdata = mem[req_a[i][slot]];
      req_v[i][slot] = 0;
    end else begin
      rdata = 16'($urandom);
    end
    if (rd) begin
      due = (cyc + lat_p[i]) % 16;
      req_v[i][due] = 1;
      req_a[i][due] = addr;
    end
  endtask

  task automatic compare_inst(input int i, input logic [7:0] addr,
                              input logic rd, input logic bsy,
                              input logic [3:0] sh, input logic [3:0] sl,
                              input logic [3:0] rh, input logic [3:0] rl);
    string p;
    logic [7:0] eb;
    p  = (i == 0) ? "a" : "b";
    eb = byte_sel ? m_data[i][15:8] : m_data[i][7:0];
    check({p, ".mem_addr"}, 16'(addr), 16'(m_addr[i]));
    check({p, ".mem_rd"},   16'(rd),   16'(m_t[i] == 0 && !reset));
    check({p, ".busy"},     16'(bsy),  16'(m_t[i] >= 0));
    check({p, ".S_hi"},     16'(sh),   16'(m_addr[i][7:4]));
    check({p, ".S_lo"},     16'(sl),   16'(m_addr[i][3:0]));
    check({p, ".R_hi"},     16'(rh),   16'(eb[7:4]));
    check({p, ".R_lo"},     16'(rl),   16'(eb[3:0]));
  endtask

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      compare_inst(0, addr_a, rd_a, busy_a, s_hi_a, s_lo_a, r_hi_a, r_lo_a);
      compare_inst(1, addr_b, rd_b, busy_b, s_hi_b, s_lo_b, r_hi_b, r_lo_b);
      if (rd_a) rd_cnt_a++;
      if (rd_b) rd_cnt_b++;
    end
    mem_cycle(0, rd_a, addr_a, rdata_a);
    mem_cycle(1, rd_b, addr_b, rdata_b);
  end

  // ---------------------------------------------------------------------------
  // Driver tasks: inputs change 2 time units after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input logic d);
    dir = d;
    step_btn = 1'b1;
    tick(10);
    step_btn = 1'b0;
    tick(10);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int base_a;
    int base_b;
    logic [7:0] exp_b;
    bit found;
    int n;

    for (int k = 0; k < 256; k++) mem[k] = 16'($urandom);
    mem[0] = 16'hA55A;
    mem[5] = 16'hC3C3;

    // Reset state, asserted before the first clock edge.
    #3 reset = 1'b1;
    #1 chk_en = 1'b1;
    check("rst.busy_a", 16'(busy_a), 16'h1);
    check("rst.rd_a",   16'(rd_a),   16'h0);
    check("rst.addr_a", 16'(addr_a), 16'h00);
    check("rst.R_a",    16'({r_hi_a, r_lo_a}), 16'h00);
    tick(3);

    // Automatic read of 0x00 after release.
    reset = 1'b0;
    #1;
    check("auto.rd_a",   16'(rd_a),   16'h1);
    check("auto.addr_a", 16'(addr_a), 16'h00);
    @(negedge clk);
    check("auto.busy_a_c0", 16'(busy_a), 16'h1);
    @(negedge clk);
    check("auto.busy_a_c1", 16'(busy_a), 16'h1);
    @(negedge clk);
    check("auto.busy_a_c2", 16'(busy_a), 16'h0);
    check("auto.R_hi_a", 16'(r_hi_a), 16'h5);
    check("auto.R_lo_a", 16'(r_lo_a), 16'hA);
    check("auto.S_a",    16'({s_hi_a, s_lo_a}), 16'h00);
    #1 byte_sel = 1'b1;
    #1;
    check("bytesel.R_hi_a", 16'(r_hi_a), 16'hA);
    check("bytesel.R_lo_a", 16'(r_lo_a), 16'h5);
    byte_sel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("auto.busy_b", 16'(busy_b), 16'h0);
    check("auto.R_b",    16'({r_hi_b, r_lo_b}), 16'h5A);
    tick(1);

    // Bouncing button then a steady press: exactly one step on instance a.
    base_a = rd_cnt_a;
    dir = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step_btn = ((k / 2) % 2 == 0);
      tick(1);
    end
    step_btn = 1'b1;
    tick(10);
    step_btn = 1'b0;
    tick(12);
    check("bounce.addr_a", 16'(addr_a), 16'h01);
    check("bounce.rd_cnt_a", 16'(rd_cnt_a - base_a), 16'd1);

    // Address wrap in both directions.
    press(1'b1);
    press(1'b1);
    check("wrap.dec_addr_a", 16'(addr_a), 16'hFF);
    press(1'b0);
    check("wrap.inc_addr_a", 16'(addr_a), 16'h00);
    press(1'b1);
    check("wrap.dec2_addr_a", 16'(addr_a), 16'hFF);
    check("wrap.S_a", 16'({s_hi_a, s_lo_a}), 16'hFF);

    // Second step pulse lands in WAIT of instance b and must be dropped.
    exp_b  = m_addr[1] + 8'd1;
    base_b = rd_cnt_b;
    dir = 1'b0;
    step_btn = 1'b1; tick(1);
    step_btn = 1'b0; tick(1);
    step_btn = 1'b1; tick(12);
    step_btn = 1'b0; tick(12);
    check("waitpulse.addr_b", 16'(addr_b), 16'(exp_b));
    check("waitpulse.rd_cnt_b", 16'(rd_cnt_b - base_b), 16'd1);
    check("waitpulse.addr_a", 16'(addr_a), 16'h00);

    // Reset the cycle after the request for 0x05 on instance a.
    repeat (4) press(1'b0);
    check("pre_rst.addr_a", 16'(addr_a), 16'h04);
    step_btn = 1'b1;
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick(1);
      if (rd_a) found = 1;
    end
    check("midrd.rd_seen", 16'(found), 16'h1);
    check("midrd.addr_a", 16'(addr_a), 16'h05);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrd.rst_addr_a", 16'(addr_a), 16'h00);
    check("midrd.rst_rd_a",   16'(rd_a),   16'h0);
    check("midrd.rst_busy_a", 16'(busy_a), 16'h1);
    check("midrd.rst_R_a",    16'({r_hi_a, r_lo_a}), 16'h00);
    step_btn = 1'b0;
    tick(4);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("midrd.after_busy_a", 16'(busy_a), 16'h0);
    check("midrd.after_R_a", 16'({r_hi_a, r_lo_a}), 16'h5A);
    check("midrd.after_addr_a", 16'(addr_a), 16'h00);
    tick(1);

    // Randomized phase: bursty button, per-cycle dir/byte_sel, rare resets.
    n = 0;
    while (n < 1500) begin
      int len;
      len = $urandom_range(1, 9);
      step_btn = 1'($urandom_range(0, 1));
      for (int k = 0; k < len; k++) begin
        dir      = 1'($urandom_range(0, 1));
        byte_sel = 1'($urandom_range(0, 1));
        tick(1);
        n++;
      end
      if ($urandom_range(0, 40) == 0) begin
        reset = 1'b1;
        tick($urandom_range(1, 3));
        reset = 1'b0;
      end
    end
    step_btn = 1'b0;
    tick(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_view_ctrl.md
MEM_VIEW_CTRL -- requirements
Module: mem_view_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable synchronized samples required to accept a button level change.
REQ-002 SHALL have parameter RD_LATENCY, default 1, range 1-7, meaning clock cycles from mem_rd assertion to mem_rdata valid.
REQ-003 SHALL have port clk_in  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port step_btn  input  1  raw, unsynchronized, bouncing pushbutton.
REQ-006 SHALL have port dir  input  1  step direction: 0 = increment address, 1 = decrement.
REQ-007 SHALL have port byte_sel  input  1  displayed data byte: 0 = mem_rdata[7:0], 1 = mem_rdata[15:8].
REQ-008 SHALL have port mem_rdata  input  16  memory read data, valid RD_LATENCY cycles after mem_rd.
REQ-009 SHALL have port mem_addr  output  8  current inspection address.
REQ-010 SHALL have port mem_rd  output  1  one-cycle read strobe.
REQ-011 SHALL have port busy  output  1  high while a read is in progress.
REQ-012 SHALL have ports S_hi, S_lo  output  4 each  mem_addr[7:4], mem_addr[3:0], for the display controller address digits.
REQ-013 SHALL have ports R_hi, R_lo  output  4 each  high and low nibbles of the selected latched data byte, for the display controller data digits.

Function
REQ-014 step_btn SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle SHALL clear the counter.
REQ-016 A rising edge of the debounced level SHALL produce exactly one 1-cycle step pulse; falling edges SHALL produce nothing.
REQ-017 FSM states: IDLE, READ, WAIT, LATCH.
REQ-018 IDLE + step pulse: mem_addr SHALL become mem_addr+1 (dir=0) or mem_addr-1 (dir=1), modulo 256, and the FSM SHALL go to READ on the same edge.
REQ-019 Address wrap: 0xFF+1 SHALL give 0x00; 0x00-1 SHALL give 0xFF.
REQ-020 READ: mem_rd SHALL be 1 for exactly this one cycle with the new mem_addr stable; next state SHALL be WAIT.
REQ-021 WAIT: the FSM SHALL stay for RD_LATENCY-1 cycles, then go to LATCH; with RD_LATENCY=1, WAIT SHALL last 0 cycles (READ goes directly to LATCH).
REQ-022 LATCH: mem_rdata SHALL be captured into a 16-bit data register; next state SHALL be IDLE.
REQ-023 busy SHALL be 1 in READ, WAIT, LATCH and 0 in IDLE.
REQ-024 Step pulses arriving while not in IDLE SHALL be discarded, not queued.
REQ-025 dir SHALL be sampled only on the cycle the step pulse is accepted.
REQ-026 R_hi/R_lo SHALL be combinational from the latched data register and byte_sel; a byte_sel change SHALL update them without a memory read.
REQ-027 S_hi/S_lo SHALL track mem_addr, and R SHALL show the previous latched data until LATCH completes.

Reset
REQ-028 On reset assertion, these values SHALL apply immediately, independent of clk_in: mem_addr=0x00, data register=0x0000, mem_rd=0, debounced level=0, debounce counter=0, synchronizer flops=0, FSM=READ, busy=1.
REQ-029 After reset deassertion, the block SHALL perform one automatic read of address 0x00 (READ->...->LATCH->IDLE) without a step pulse.
REQ-030 Reset asserted mid-read SHALL abandon the read with no latch, and the automatic read of 0x00 SHALL follow deassertion.

Verification
REQ-031 DEBOUNCE_CYCLES=4, memory model 0x00->0xA55A; release reset -> one mem_rd at addr 0x00, busy high 2 cycles, then R_hi/R_lo=5/A, S=00; with byte_sel=1, R_hi/R_lo=A/5.
REQ-032 step_btn toggling every 2 cycles for 20 cycles, then held high 10 cycles -> exactly one step pulse; mem_addr 0x00->0x01; exactly one mem_rd.
REQ-033 mem_addr=0xFF, dir=0, clean press -> mem_addr=0x00; then dir=1 press -> mem_addr=0xFF; S_hi/S_lo=F/F.
REQ-034 RD_LATENCY=3, step pulse forced during WAIT -> pulse ignored; address advances by 1 only; mem_rd asserted once; data latched exactly 3 cycles after mem_rd.
REQ-035 Reset asserted the cycle after mem_rd for address 0x05 -> outputs 0 immediately (asynchronously); after release, read of 0x00 occurs and data from 0x05 is never latched.
